sha256_msg_loader: RTL and testbench
====================================

# sha256_msg_loader

Upstream/downstream controller for `sha256_core`. It accepts a byte-stream message of 1 to 55 bytes and pads it to one 512-bit SHA-256 block. It then writes the block into the core's byte-addressed word memory, starts the core, waits for `o_irq`, reads the 32 digest bytes back, returns the core to idle, and presents the 256-bit digest on a valid/ready output. Before every message it resets the core, because the core does not reinitialise its hash variables between runs.

## Interface

Parameters:
- `CORE_RST_CYCLES`, default 2: cycles `o_core_rst_n` is held low per job (≥1).
- `IRQ_TIMEOUT`, default 127: maximum cycles in WAIT before abort (≥70).

Ports (name, direction, width, meaning):
- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: one clock; reset is asynchronous and active-low.
- `i_s_data`, in, 8: message byte.
- `i_s_valid`, in, 1: byte valid.
- `i_s_last`, in, 1: final byte of the message.
- `o_s_ready`, out, 1: byte accepted when `i_s_valid & o_s_ready`.
- `o_digest`, out, 256: digest in big-endian order; byte 0 of the hash is in `[255:248]`.
- `o_digest_valid`, out, 1: digest available.
- `i_digest_ready`, in, 1: digest consumer accepts.
- `o_err`, out, 1: one-cycle pulse on an oversize message or an IRQ timeout.
- `o_core_rst_n`, out, 1: registered reset to the core, active-low.
- `o_w_addr`, out, 7: core address.
- `o_data8`, out, 8: core write data.
- `o_we`, out, 1: core write enable.
- `i_irq`, in, 1: core `o_irq`.
- `i_data_mux`, in, 8: core `o_data_mux`, which is a combinational read.

## Operation

- **States:** CRST, RECV, PAD, START, WAIT, READ, ACK, DONE, DRAIN. The reset state is CRST.
- **Reset values:** `o_core_rst_n=0`, `o_s_ready=0`, `o_we=0`, `o_w_addr=64`, `o_data8=0`, `o_digest=0`, `o_digest_valid=0`, `o_err=0`. The byte counter `n` is 0.
- **CRST:** hold `o_core_rst_n` low for `CORE_RST_CYCLES` cycles, release it, then go to RECV with `n=0`.
- **RECV:** `o_s_ready=1`.
  - Each accepted byte k is written to core address `63-k` (message byte 0 goes to address 63, the MSB of W0).
  - `n` increments on every accepted byte.
  - An accepted byte with `i_s_last` goes to PAD.
  - Accepting byte index 55 without `last` goes to DRAIN.
- **PAD:** one write per cycle for block bytes `n..63`:
  - byte `n` = `0x80`;
  - bytes `n+1..61` = `0x00`;
  - byte 62 = `bitlen[15:8]`;
  - byte 63 = `bitlen[7:0]`, where `bitlen = 8*n` (16-bit, at most 440).
- **START:** write `0x01` to address 65 (the STATUS register).
- **WAIT:** `o_we=0`, `o_w_addr=64`.
  - `i_irq=1` goes to READ.
  - A timeout counter reaching `IRQ_TIMEOUT` pulses `o_err` and goes to CRST.
- **READ:** 32 cycles with `o_w_addr = 70+j`, j=0..31.
  - The same cycle, `i_data_mux` is captured into `o_digest[8j+7:8j]`.
  - Address 101 is the MSB of `a`.
- **ACK:** write `0x01` to address 65, so the core leaves OUT.
- **DONE:** `o_digest_valid=1` and `o_digest` is held stable. On `i_digest_ready`, go to CRST.
- **DRAIN:** `o_s_ready=1`.
  - Bytes are discarded and no core writes occur.
  - Accepting `last` pulses `o_err` and goes to CRST.
- Zero-length messages are not supported. Every message carries at least one byte.
- `o_digest` is updated only in READ.

## Timing

- All core-side outputs are registered. A byte accepted at cycle t appears as `o_we`/`o_w_addr`/`o_data8` at t+1.
- `o_we` is never asserted in WAIT, READ, DONE, CRST or DRAIN. The core's FSM does not advance while `o_we` is high.
- The last RECV write and the first PAD write are on consecutive cycles. PAD lasts exactly `64-n` cycles.
- The core raises `i_irq` 66 cycles after the START write (1 INIT + 64 ROUND + 1 MATH).
- Latency from `last` accepted to `o_digest_valid` = `(64-n) + 1 + 66 + 32 + 1 + 1` cycles, plus any `i_irq` delay.
- `o_s_ready` drops the cycle after `last` is accepted and stays low until the next RECV.
- `i_s_valid` while `o_s_ready=0` is ignored, with no loss: the byte stays pending at the source.
- `i_rst_n` asserted in any state returns to the reset values immediately. After release, the block starts in CRST, which also resets the core.
- `o_err` and `o_digest_valid` are never high in the same cycle.

## Structure

- Shared package `sha256_pkg` holds:
  - the address constants `W_MEM_LAST=63`, `STATUS_REG=65`, `DIGEST_START_ADDR=70`, `DIGEST_END_ADDR=101`, `IDLE_ADDR=64`;
  - `STATUS_START=8'h01`;
  - the state encoding for this block.
- The block has a single flat FSM with counters `n[5:0]`, `j[4:0]` and a timeout/reset counter. No sub-module is used.
- The core is instantiated beside this block in the integration top, not inside it.

## Test plan

1. **"abc":** message `61 62 63`, `last` on `63` → `o_digest = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad`. Core writes: address 63 = `61`, address 60 = `80`, address 0 = `18`.
2. **55-byte boundary:** 55 × `0x61` → digest matches the software model. PAD lasts 9 cycles. Address 8 = `80`, address 1 = `01`, address 0 = `B8`.
3. **Oversize:** 60-byte message → `o_err` pulses once after the 60th byte. No `o_digest_valid`. The next "abc" message still yields the correct digest.
4. **Back-to-back:** "abc" then "abc" again → both digests are identical. This checks that the core is reset between jobs.
5. **Backpressure:** `i_digest_ready` held low for 20 cycles → `o_digest_valid` and `o_digest` stay stable. `o_s_ready` stays 0 until the handshake plus `CORE_RST_CYCLES` + 1.
6. **Fault and reset:** model `i_irq` tied to 0 → `o_err` pulses after `IRQ_TIMEOUT` cycles in WAIT. `i_rst_n` pulsed mid-READ → all outputs return to their reset values and the next job completes correctly.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: address map, status codes and loader state encoding shared with the core
package sha256_pkg;
  localparam logic [6:0] W_MEM_LAST        = 7'd63;
  localparam logic [6:0] IDLE_ADDR         = 7'd64;
  localparam logic [6:0] STATUS_REG        = 7'd65;
  localparam logic [6:0] DIGEST_START_ADDR = 7'd70;
  localparam logic [6:0] DIGEST_END_ADDR   = 7'd101;
  localparam logic [7:0] STATUS_START      = 8'h01;
  typedef enum logic [3:0] {
    ST_CRST, ST_RECV, ST_PAD, ST_START, ST_WAIT, ST_READ, ST_ACK, ST_DONE, ST_DRAIN
  } loader_state_e;
endpackage

// File: rtl/sha256_msg_loader.sv
// sha256_msg_loader: pads a 1..55 byte message into one block, drives sha256_core, returns the digest
module sha256_msg_loader
  import sha256_pkg::*;
#(
  parameter int CORE_RST_CYCLES = 2,
  parameter int IRQ_TIMEOUT     = 127
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [7:0]   i_s_data,
  input  logic         i_s_valid,
  input  logic         i_s_last,
  output logic         o_s_ready,
  output logic [255:0] o_digest,
  output logic         o_digest_valid,
  input  logic         i_digest_ready,
  output logic         o_err,
  output logic         o_core_rst_n,
  output logic [6:0]   o_w_addr,
  output logic [7:0]   o_data8,
  output logic         o_we,
  input  logic         i_irq,
  input  logic [7:0]   i_data_mux
);
  localparam int CW = $clog2(IRQ_TIMEOUT + 1);
  loader_state_e state, state_d;
  logic [5:0] n, n_d;
  logic [4:0] j, j_d;
  logic [CW-1:0] cnt, cnt_d;
  logic we_d, err_d, acc;
  logic [6:0] addr_d;
  logic [7:0] data8_d;
  logic [255:0] digest_d;
  logic [15:0] bitlen;
  logic [5:0] b;
  assign acc = i_s_valid & o_s_ready;
  assign bitlen = {7'd0, n, 3'd0};
  // cnt doubles as core-reset timer, pad byte pointer and irq timeout
  assign b = cnt[5:0];
  // next state and next values of every registered output
  always_comb begin
    state_d = state;
    n_d = n;
    j_d = j;
    cnt_d = cnt;
    we_d = 1'b0;
    addr_d = IDLE_ADDR;
    data8_d = 8'h00;
    digest_d = o_digest;
    err_d = 1'b0;
    case (state)
      ST_CRST: begin
        n_d = '0;
        cnt_d = cnt + 1'b1;
        if (cnt == CW'(CORE_RST_CYCLES - 1)) begin
          state_d = ST_RECV;
          cnt_d = '0;
        end
      end
      ST_RECV: if (acc) begin
        n_d = n + 6'd1;
        if (n == 6'd55) begin
          state_d = i_s_last ? ST_CRST : ST_DRAIN;
          err_d = i_s_last;
          cnt_d = '0;
        end else begin
          we_d = 1'b1;
          addr_d = W_MEM_LAST - {1'b0, n};
          data8_d = i_s_data;
          if (i_s_last) begin
            state_d = ST_PAD;
            cnt_d = CW'(n + 6'd1);
          end
        end
      end
      ST_PAD: begin
        we_d = 1'b1;
        addr_d = W_MEM_LAST - {1'b0, b};
        data8_d = (b == n) ? 8'h80 : (b == 6'd62) ? bitlen[15:8] : (b == 6'd63) ? bitlen[7:0] : 8'h00;
        cnt_d = cnt + 1'b1;
        if (b == 6'd63) state_d = ST_START;
      end
      ST_START: begin
        we_d = 1'b1;
        addr_d = STATUS_REG;
        data8_d = STATUS_START;
        cnt_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_irq) begin
          state_d = ST_READ;
          j_d = '0;
          addr_d = DIGEST_START_ADDR;
        end else if (cnt == CW'(IRQ_TIMEOUT - 1)) begin
          err_d = 1'b1;
          state_d = ST_CRST;
          cnt_d = '0;
        end else cnt_d = cnt + 1'b1;
      end
      ST_READ: begin
        digest_d[{j, 3'b000} +: 8] = i_data_mux;
        j_d = j + 5'd1;
        addr_d = DIGEST_START_ADDR + {2'b00, j} + 7'd1;
        if (o_w_addr == DIGEST_END_ADDR) begin
          state_d = ST_ACK;
          addr_d = IDLE_ADDR;
        end
      end
      ST_ACK: begin
        we_d = 1'b1;
        addr_d = STATUS_REG;
        data8_d = STATUS_START;
        state_d = ST_DONE;
      end
      ST_DONE: if (i_digest_ready) begin
        state_d = ST_CRST;
        cnt_d = '0;
      end
      ST_DRAIN: if (acc && i_s_last) begin
        err_d = 1'b1;
        state_d = ST_CRST;
        cnt_d = '0;
      end
      default: begin
        state_d = ST_CRST;
        cnt_d = '0;
      end
    endcase
  end
  // state, counters and all outputs are registered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_CRST;
      n <= '0;
      j <= '0;
      cnt <= '0;
      o_core_rst_n <= 1'b0;
      o_s_ready <= 1'b0;
      o_we <= 1'b0;
      o_w_addr <= IDLE_ADDR;
      o_data8 <= 8'h00;
      o_digest <= '0;
      o_digest_valid <= 1'b0;
      o_err <= 1'b0;
    end else begin
      state <= state_d;
      n <= n_d;
      j <= j_d;
      cnt <= cnt_d;
      o_core_rst_n <= state_d != ST_CRST;
      o_s_ready <= state_d == ST_RECV || state_d == ST_DRAIN;
      o_we <= we_d;
      o_w_addr <= addr_d;
      o_data8 <= data8_d;
      o_digest <= digest_d;
      o_digest_valid <= state_d == ST_DONE;
      o_err <= err_d;
    end
  end
endmodule

// File: tb/tb_sha256_msg_loader.sv
// tb_sha256_msg_loader: random messages against a behavioural sha256_core and a SHA-256 reference
module tb_sha256_msg_loader;
  localparam int CRC = 3;
  localparam int TMO = 90;
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic clk = 1'b0;
  logic rst_n, s_valid, s_last, s_ready, digest_valid, digest_ready, err, core_rst_n, we, irq;
  logic [7:0] s_data, data8, data_mux;
  logic [6:0] w_addr;
  logic [255:0] digest;

  sha256_msg_loader #(.CORE_RST_CYCLES(CRC), .IRQ_TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_s_data(s_data), .i_s_valid(s_valid), .i_s_last(s_last),
    .o_s_ready(s_ready), .o_digest(digest), .o_digest_valid(digest_valid), .i_digest_ready(digest_ready),
    .o_err(err), .o_core_rst_n(core_rst_n), .o_w_addr(w_addr), .o_data8(data8), .o_we(we),
    .i_irq(irq), .i_data_mux(data_mux));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, cyc = 0;
  int err_cnt = 0, valid_cnt = 0, excl_bad = 0, t_start = 0, t_err = 0;
  int wr_cyc [64];
  logic valid_prev = 1'b0;
  logic [7:0] msg [64];
  logic [255:0] last_digest;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // textbook SHA-256 of msg[0..len-1]: append 0x80, zeros, 64-bit bit length
  function automatic logic [255:0] ref_digest(input int len);
    logic [511:0] blk;
    blk = '0;
    for (int k = 0; k < len; k++) blk[511 - 8*k -: 8] = msg[k];
    blk[511 - 8*len -: 8] = 8'h80;
    blk[63:0] = 64'(len * 8);
    return sha_compress(IV, blk);
  endfunction

  // behavioural sha256_core: byte memory, block byte b lives at address 63-b
  logic [7:0] cmem [128];
  logic [255:0] core_h, nh;
  logic busy, irq_en;
  int bcnt;
  assign irq = irq_en & core_irq;
  logic core_irq;
  assign data_mux = cmem[w_addr];

  function automatic logic [511:0] core_blk();
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[511 - 8*i -: 8] = cmem[63 - i];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!core_rst_n) begin
      core_h <= IV;
      busy <= 1'b0;
      core_irq <= 1'b0;
      bcnt <= 0;
    end else begin
      if (we) begin
        cmem[w_addr] <= data8;
        if (w_addr == 7'd65 && data8 == 8'h01) begin
          if (core_irq) core_irq <= 1'b0;
          else if (!busy) begin busy <= 1'b1; bcnt <= 0; end
        end
      end
      if (busy) begin
        bcnt <= bcnt + 1;
        if (bcnt == 65) begin
          nh = sha_compress(core_h, core_blk());
          core_h <= nh;
          for (int i = 0; i < 32; i++) cmem[70 + i] <= nh[8*i +: 8];
          busy <= 1'b0;
          core_irq <= 1'b1;
        end
      end
    end
  end

  // observe writes, error pulses and digest handshakes between clock edges
  always @(negedge clk) begin
    if (we && w_addr < 7'd64) wr_cyc[w_addr[5:0]] = cyc;
    if (we && w_addr == 7'd65 && data8 == 8'h01 && !core_irq) t_start = cyc;
    if (err) begin err_cnt++; t_err = cyc; end
    if (err && digest_valid) excl_bad++;
    if (digest_valid && !valid_prev) valid_cnt++;
    valid_prev = digest_valid;
  end

  task automatic send(input int len);
    int k, guard;
    k = 0;
    guard = 0;
    while (k < len && guard < 3000) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) s_valid = 1'b0;
      else begin
        s_valid = 1'b1;
        s_data = msg[k];
        s_last = (k == len - 1);
        if (s_ready) k++;
      end
      guard++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
    check("send_bound", 256'(k), 256'(len));
  endtask

  task automatic run_job(input int len, input int hold, input string tag);
    logic [255:0] exp, snap;
    int g;
    bit stable;
    exp = ref_digest(len);
    send(len);
    g = 0;
    while (!digest_valid && g < 600) begin @(negedge clk); g++; end
    check({tag, "_valid"}, 256'(digest_valid), 256'(1));
    snap = digest;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!digest_valid || digest !== snap) stable = 1'b0;
    end
    if (hold > 0) check({tag, "_stable"}, 256'(stable), 256'(1));
    check({tag, "_digest"}, digest, exp);
    last_digest = digest;
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    g = 0;
    while (!s_ready && g < 20) begin g++; @(negedge clk); end
    check({tag, "_rdy_gap"}, 256'(g), 256'(CRC));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_core_rst_n"}, 256'(core_rst_n), 256'(0));
    check({tag, "_s_ready"}, 256'(s_ready), 256'(0));
    check({tag, "_we"}, 256'(we), 256'(0));
    check({tag, "_addr"}, 256'(w_addr), 256'(64));
    check({tag, "_data8"}, 256'(data8), 256'(0));
    check({tag, "_digest"}, digest, 256'(0));
    check({tag, "_valid"}, 256'(digest_valid), 256'(0));
    check({tag, "_err"}, 256'(err), 256'(0));
  endtask

  task automatic set_abc();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    int e0, v0, g, len;
    logic [255:0] first;
    for (int i = 0; i < 128; i++) cmem[i] = 8'h00;
    irq_en = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; digest_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;

    set_abc();
    run_job(3, 0, "abc");
    check("abc_const", last_digest, ABC);
    check("abc_a63", 256'(cmem[63]), 256'(8'h61));
    check("abc_a60", 256'(cmem[60]), 256'(8'h80));
    check("abc_a0", 256'(cmem[0]), 256'(8'h18));
    check("abc_pad_len", 256'(wr_cyc[0] - wr_cyc[61]), 256'(61));

    for (int i = 0; i < 55; i++) msg[i] = 8'h61;
    run_job(55, 0, "b55");
    check("b55_pad_len", 256'(wr_cyc[0] - wr_cyc[9]), 256'(9));
    check("b55_a8", 256'(cmem[8]), 256'(8'h80));
    check("b55_a1", 256'(cmem[1]), 256'(8'h01));
    check("b55_a0", 256'(cmem[0]), 256'(8'hb8));

    for (int i = 0; i < 64; i++) msg[i] = 8'($urandom);
    e0 = err_cnt; v0 = valid_cnt;
    send(60);
    repeat (6) @(negedge clk);
    check("over_err", 256'(err_cnt - e0), 256'(1));
    check("over_novalid", 256'(valid_cnt - v0), 256'(0));
    set_abc();
    run_job(3, 0, "post_over");
    check("post_over_const", last_digest, ABC);

    run_job(3, 0, "b2b1");
    first = last_digest;
    run_job(3, 0, "b2b2");
    check("b2b_same", last_digest, first);

    for (int i = 0; i < 64; i++) msg[i] = 8'($urandom);
    run_job(int'($urandom_range(1, 55)), 20, "bp");

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 64; i++) msg[i] = 8'($urandom);
      len = int'($urandom_range(1, 55));
      run_job(len, int'($urandom_range(0, 5)), $sformatf("rnd%0d", r));
    end

    irq_en = 1'b0;
    set_abc();
    e0 = err_cnt; v0 = valid_cnt;
    send(3);
    g = 0;
    while (err_cnt == e0 && g < 400) begin @(negedge clk); g++; end
    check("tmo_err", 256'(err_cnt - e0), 256'(1));
    check("tmo_cycles", 256'(t_err - t_start), 256'(TMO));
    check("tmo_novalid", 256'(valid_cnt - v0), 256'(0));
    irq_en = 1'b1;

    send(3);
    g = 0;
    while (w_addr != 7'd80 && g < 400) begin @(negedge clk); g++; end
    check("read_reached", 256'(w_addr), 256'(80));
    rst_n = 1'b0;
    #1;
    check_reset("midread");
    @(negedge clk);
    rst_n = 1'b1;
    run_job(3, 0, "post_rst");
    check("post_rst_const", last_digest, ABC);

    check("err_valid_excl", 256'(excl_bad), 256'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
